text_decryption: RTL

- Front-end controller for the decrypt direction of the DES text demo.
- Collects a 64-bit key and a 64-bit ciphertext from 16 slide switches over four button presses each.
- Hands both to an external DES decrypt core through a start/done handshake, then presents the 64-bit plaintext 16 bits at a time for the four-digit hex display.
- Sits beside the encryption front-end at board top; the top-level instantiates the hex display driver on disp_word.

---
 rtl/des_demo_pkg.sv | 59 +++++
 rtl/btn_event.sv | 38 +++
 rtl/text_decryption.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/des_demo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : des_demo_pkg
// Brief   : Shared state codes, word-select codes, display patterns and word
//           helpers for the DES text demo front-ends.
// Rev     : 1.0  initial release
// ============================================================================
package des_demo_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_IN_KEY   = 4'd1,
        ST_SHOW_KEY = 4'd2,
        ST_IN_CT    = 4'd3,
        ST_SHOW_CT  = 4'd4,
        ST_WAIT_GO  = 4'd5,
        ST_DECR     = 4'd6,
        ST_SHOW_PT  = 4'd7,
        ST_ERROR    = 4'd8
    } state_t;

    localparam logic [1:0]  c_SEL_W0      = 2'd0;
    localparam logic [1:0]  c_SEL_W1      = 2'd1;
    localparam logic [1:0]  c_SEL_W2      = 2'd2;
    localparam logic [1:0]  c_SEL_W3      = 2'd3;

    localparam logic [15:0] c_ERR_PATTERN = 16'hEEEE;
    localparam logic [15:0] c_BLANK       = 16'h0000;

    // Word 0 is the least significant 16 bits, word 3 the most significant.
    function automatic logic [15:0] get_word(input logic [63:0] v, input logic [1:0] sel);
        logic [15:0] w;
        w = v[15:0];
        case (sel)
            c_SEL_W0: w = v[15:0];
            c_SEL_W1: w = v[31:16];
            c_SEL_W2: w = v[47:32];
            c_SEL_W3: w = v[63:48];
            default:  w = v[15:0];
        endcase
        return w;
    endfunction

    function automatic logic [63:0] put_word(input logic [63:0] v, input logic [1:0] idx,
                                             input logic [15:0] w);
        logic [63:0] r;
        r = v;
        case (idx)
            c_SEL_W0: r[15:0]  = w;
            c_SEL_W1: r[31:16] = w;
            c_SEL_W2: r[47:32] = w;
            c_SEL_W3: r[63:48] = w;
            default:  r        = v;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_event.sv
`default_nettype none
// ============================================================================
// Module  : btn_event
// Brief   : 2-FF synchronizer plus registered falling-edge pulse for an
//           active-low push button (one pulse per press, no repeats on hold).
// Rev     : 1.0  initial release
// ============================================================================
module btn_event (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    // Pulse appears on the third edge after the pin falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_btn_n;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_prev & ~r_sync;
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/text_decryption.sv
`default_nettype none
// ============================================================================
// Module  : text_decryption
// Brief   : Decrypt-side front-end: collects key and ciphertext from switches,
//           drives an external DES core, and pages the plaintext to the display.
// Rev     : 1.0  initial release
// ============================================================================
module text_decryption
    import des_demo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TW             = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_data,
    input  logic        decr_go,
    input  logic [15:0] user_input,
    input  logic [1:0]  select_disp,
    output logic [63:0] core_key,
    output logic [63:0] core_data,
    output logic        core_start,
    input  logic        core_done,
    input  logic [63:0] core_result,
    output logic [63:0] plaintext,
    output logic        done,
    output logic        error,
    output logic [15:0] disp_word,
    output logic [3:0]  state_dbg
);

    localparam logic [TW-1:0] c_TIMEOUT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] c_CNT_ONE = TW'(1);

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_wc,    w_wc_nxt;
    logic [63:0]   r_key,   w_key_nxt;
    logic [63:0]   r_ct,    w_ct_nxt;
    logic [63:0]   r_pt,    w_pt_nxt;
    logic [TW-1:0] r_cnt,   w_cnt_nxt;
    logic [15:0]   r_disp,  w_disp_nxt;
    logic          w_start;
    logic          w_send_ev;
    logic          w_go_ev;

    btn_event u_send_ev (
        .clk     (clk),
        .rst     (rst),
        .i_btn_n (send_data),
        .o_pulse (w_send_ev)
    );

    btn_event u_go_ev (
        .clk     (clk),
        .rst     (rst),
        .i_btn_n (decr_go),
        .o_pulse (w_go_ev)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_wc    <= '0;
            r_key   <= '0;
            r_ct    <= '0;
            r_pt    <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wc    <= w_wc_nxt;
            r_key   <= w_key_nxt;
            r_ct    <= w_ct_nxt;
            r_pt    <= w_pt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_disp  <= w_disp_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wc_nxt    = r_wc;
        w_key_nxt   = r_key;
        w_ct_nxt    = r_ct;
        w_pt_nxt    = r_pt;
        w_cnt_nxt   = r_cnt;
        w_disp_nxt  = c_BLANK;
        w_start     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_wc_nxt    = '0;
                w_state_nxt = ST_IN_KEY;
            end

            // First press fills the top word, fourth press the bottom word.
            ST_IN_KEY: begin
                w_disp_nxt = user_input;
                if (w_send_ev) begin
                    w_key_nxt = put_word(r_key, c_SEL_W3 - r_wc, user_input);
                    w_wc_nxt  = r_wc + 2'd1;
                    if (r_wc == 2'd3)
                        w_state_nxt = ST_SHOW_KEY;
                end
            end

            ST_SHOW_KEY: begin
                w_disp_nxt = get_word(r_key, select_disp);
                if (w_send_ev)
                    w_state_nxt = ST_IN_CT;
            end

            ST_IN_CT: begin
                w_disp_nxt = user_input;
                if (w_send_ev) begin
                    w_ct_nxt = put_word(r_ct, c_SEL_W3 - r_wc, user_input);
                    w_wc_nxt = r_wc + 2'd1;
                    if (r_wc == 2'd3)
                        w_state_nxt = ST_SHOW_CT;
                end
            end

            ST_SHOW_CT: begin
                w_disp_nxt = get_word(r_ct, select_disp);
                if (w_send_ev)
                    w_state_nxt = ST_WAIT_GO;
            end

            ST_WAIT_GO: begin
                if (w_go_ev) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DECR;
                end
            end

            // Counter is zero only on the first DECR cycle, which marks the start pulse.
            ST_DECR: begin
                w_start   = (r_cnt == '0);
                w_cnt_nxt = r_cnt + c_CNT_ONE;
                if (core_done) begin
                    w_pt_nxt    = core_result;
                    w_state_nxt = ST_SHOW_PT;
                end else if (w_cnt_nxt == c_TIMEOUT) begin
                    w_state_nxt = ST_ERROR;
                end
            end

            ST_SHOW_PT: begin
                w_disp_nxt = get_word(r_pt, select_disp);
                if (w_send_ev) begin
                    w_key_nxt   = '0;
                    w_ct_nxt    = '0;
                    w_pt_nxt    = '0;
                    w_wc_nxt    = '0;
                    w_state_nxt = ST_IN_KEY;
                end
            end

            ST_ERROR: begin
                w_disp_nxt = c_ERR_PATTERN;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign core_key   = r_key;
    assign core_data  = r_ct;
    assign core_start = w_start;
    assign plaintext  = r_pt;
    assign done       = (r_state == ST_SHOW_PT);
    assign error      = (r_state == ST_ERROR);
    assign disp_word  = r_disp;
    assign state_dbg  = r_state;

endmodule
`default_nettype wire
